// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared types and helpers for the core control blocks.
package core_ctrl_pkg;
   typedef enum logic [1:0] { BOOT, RUN, TRAP } pcseq_state_t;
   function automatic int unsigned align_mask(int unsigned instr_bytes);
      return instr_bytes - 1;
   endfunction
endpackage

// File: rtl/flush_timer.sv
// flush_timer: loadable down-counter whose nonzero flag drives a multi-cycle flush.
module flush_timer #(
   parameter int unsigned FlushCycles = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic load,
   output logic busy
);
   logic [3:0] cnt;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt <= '0;
      else if (load) cnt <= 4'(FlushCycles);
      else if (cnt != '0) cnt <= cnt - 4'd1;
   end
   assign busy = cnt != '0;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC, issues fetch requests, redirects on taken
// branches with a timed pipeline flush and traps on misaligned targets.
module pc_sequencer
   import core_ctrl_pkg::*;
#(
   parameter int unsigned         WordSize    = 32,
   parameter logic [WordSize-1:0] ResetVector = '0,
   parameter int unsigned         InstrBytes  = 4,
   parameter int unsigned         FlushCycles = 2
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                stall,
   input  logic                br_valid,
   input  logic                br_taken,
   input  logic [WordSize-1:0] br_target,
   input  logic                if_ready,
   output logic                if_valid,
   output logic [WordSize-1:0] if_addr,
   output logic [WordSize-1:0] pc,
   output logic                flush,
   output logic                misalign
);
   localparam logic [WordSize-1:0] AlignMask = WordSize'(align_mask(InstrBytes));
   localparam logic [WordSize-1:0] Step      = WordSize'(InstrBytes);
   pcseq_state_t        state, state_n;
   logic [WordSize-1:0] pc_n;
   logic                pending, pending_n, busy, redirect, aligned, accept;
   flush_timer #(.FlushCycles(FlushCycles)) u_flush_timer (
      .clk  (clk),
      .rstn (rstn),
      .load (redirect),
      .busy (busy)
   );
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= BOOT;
         pc      <= ResetVector;
         pending <= 1'b0;
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         pending <= pending_n;
      end
   end
   // Redirect outranks accept and stall; an abandoned request is simply dropped.
   always_comb begin
      if_valid  = (state == RUN) && (!stall || pending) && !busy;
      redirect  = (state == RUN) && br_valid && br_taken && !busy;
      aligned   = (br_target & AlignMask) == '0;
      accept    = if_valid && if_ready;
      state_n   = (state == BOOT) ? RUN : (redirect && !aligned) ? TRAP : state;
      pc_n      = redirect ? (aligned ? br_target : pc) : accept ? pc + Step : pc;
      pending_n = !redirect && if_valid && !if_ready;
   end
   assign if_addr  = pc;
   assign flush    = busy;
   assign misalign = state == TRAP;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench driving directed and random fetch/branch traffic.
module tb_pc_sequencer;
   localparam int FC = 2;
   logic        clk = 1'b0, rstn = 1'b0, stall = 1'b0, br_valid = 1'b0, br_taken = 1'b0, if_ready = 1'b0;
   logic [31:0] br_target = '0;
   logic        if_valid, flush, misalign;
   logic [31:0] if_addr, pc;
   typedef struct packed { logic v; logic [31:0] a; logic f; logic m; } exp_t;
   exp_t        q[$];
   int          checks = 0, errors = 0;
   bit          m_boot, m_trap, m_held;
   int          m_fl;
   logic [31:0] m_pc;

   pc_sequencer #(.WordSize(32), .ResetVector(32'h0), .InstrBytes(4), .FlushCycles(FC)) dut (
      .clk(clk), .rstn(rstn), .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
      .br_target(br_target), .if_ready(if_ready), .if_valid(if_valid), .if_addr(if_addr),
      .pc(pc), .flush(flush), .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares the DUT against the oldest expectation each cycle.
   exp_t e_mon;
   always @(negedge clk) begin
      #2;
      if (q.size() != 0) begin
         e_mon = q.pop_front();
         chk("if_valid", if_valid, e_mon.v);
         chk("if_addr", if_addr, e_mon.a);
         chk("pc", pc, e_mon.a);
         chk("flush", flush, e_mon.f);
         chk("misalign", misalign, e_mon.m);
      end
   end

   // Drives one cycle of inputs, predicts the outputs, then advances the model.
   task automatic cycle(bit s, bit bv, bit bt, logic [31:0] t, bit r);
      exp_t e;
      bit   run, red;
      stall = s; br_valid = bv; br_taken = bt; br_target = t; if_ready = r;
      run = !m_boot && !m_trap;
      e.v = run && m_fl == 0 && (!s || m_held);
      e.a = m_pc;
      e.f = m_fl != 0;
      e.m = m_trap;
      q.push_back(e);
      red = run && m_fl == 0 && bv && bt;
      if (m_fl > 0) m_fl--;
      if (red) begin
         m_fl = FC;
         m_held = 0;
         if (t % 4 == 0) m_pc = t;
         else m_trap = 1;
      end else if (e.v && r) begin
         m_pc = m_pc + 32'd4;
         m_held = 0;
      end else if (e.v) m_held = 1;
      m_boot = 0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #1;
      chk("rst_if_valid", if_valid, 0);
      chk("rst_pc", pc, 0);
      chk("rst_if_addr", if_addr, 0);
      chk("rst_flush", flush, 0);
      chk("rst_misalign", misalign, 0);
      m_boot = 1; m_trap = 0; m_held = 0; m_fl = 0; m_pc = '0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      logic [31:0] t;
      @(negedge clk);
      do_reset();
      repeat (5) cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      repeat (3) cycle(0, 0, 0, 0, 1);
      cycle(0, 1, 1, 32'h100, 1);
      cycle(0, 1, 1, 32'h200, 1);
      cycle(0, 0, 0, 0, 1);
      repeat (3) cycle(0, 0, 0, 0, 1);
      cycle(0, 1, 1, 32'hFFFF_FFFC, 1);
      repeat (2) cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      cycle(0, 1, 0, 32'h40, 1);
      repeat (2) cycle(0, 0, 0, 0, 1);
      cycle(0, 1, 1, 32'h102, 1);
      cycle(0, 0, 0, 0, 1);
      do_reset();
      repeat (3) cycle(0, 0, 0, 0, 1);
      cycle(0, 1, 1, 32'h102, 0);
      repeat (5) cycle($urandom_range(0, 1) == 0, 1, 1, 32'h300, 1);
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (m_trap && $urandom_range(0, 3) == 0) do_reset();
         t = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hC);
         if ($urandom_range(0, 15) == 0) t = t | $urandom_range(1, 3);
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, t,
               $urandom_range(0, 2) != 0);
      end
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural fetch PC and sequences instruction fetch through a valid/ready request to instruction memory.
- Consumes branch resolution from the execute-stage branch address calculator (taken flag plus target) and redirects the PC on taken branches.
- Drives a multi-cycle pipeline flush to squash wrong-path instructions, and traps on misaligned targets.
- Sits between the hazard unit, the execute-stage branch calculator and the IF stage; its `pc` output feeds the branch calculator's PC input.

Parameters:
- WordSize, 32, width of PC and addresses.
- ResetVector, 0, PC value loaded on reset.
- InstrBytes, 4, PC increment per fetch and alignment requirement; power of two.
- FlushCycles, 2, number of cycles `flush` stays asserted after a redirect; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- stall  in  1  hazard unit; blocks issue of new fetch requests.
- br_valid  in  1  EX stage holds a resolved branch/jump this cycle.
- br_taken  in  1  branch taken; qualified by br_valid.
- br_target  in  WordSize  target address from the branch calculator.
- if_ready  in  1  instruction memory accepts the request.
- if_valid  out  1  fetch request valid.
- if_addr  out  WordSize  fetch address; equals pc.
- pc  out  WordSize  current fetch PC, to the branch calculator.
- flush  out  1  squash IF/ID and ID/EX registers.
- misalign  out  1  sticky trap: a taken target was misaligned.

Behaviour:
- One clock and one reset. Reset is asynchronous, active-low. All state is registered on the rising edge of clk.
- Reset values:
  - pc = ResetVector; state = BOOT.
  - if_valid = 0, flush = 0, misalign = 0, flush_cnt = 0.
- States:
  - BOOT: one cycle, if_valid = 0. Goes to RUN unconditionally.
  - RUN: normal fetch.
  - TRAP: terminal; if_valid = 0, misalign = 1, pc frozen. Only reset exits TRAP.
- if_valid (combinational from registered state):
  - 1 in RUN when (!stall OR req_pending) AND flush_cnt == 0.
  - req_pending is a register, set when a request is presented but not accepted.
  - Once presented, a request stays valid and if_addr stays stable until accepted. Stall never withdraws it.
  - A redirect is the only exception.
- Accept: if_valid && if_ready → pc <= pc + InstrBytes (mod 2^WordSize, wraps silently); req_pending cleared.
- Redirect: br_valid && br_taken && flush_cnt == 0 in RUN.
  - If br_target mod InstrBytes == 0:
    - pc <= br_target, flush_cnt <= FlushCycles, req_pending <= 0.
    - An unaccepted request is abandoned. Memory samples if_addr only on accept.
  - If br_target is misaligned: state <= TRAP, pc unchanged, flush_cnt <= FlushCycles.
- flush = (flush_cnt != 0). It is registered, so it rises the cycle after the redirect and stays high exactly FlushCycles cycles. flush_cnt decrements each cycle while nonzero.
- If_valid is held at 0 while flush is high. The first target fetch is issued the cycle flush falls.
- Simultaneous events, in priority order:
  - Redirect beats accept in the same cycle: the accepted fetch was the old pc, and pc becomes br_target, not pc + InstrBytes.
  - Redirect beats stall.
  - br_valid with flush_cnt != 0 is a wrong-path instruction and is ignored.
  - br_valid with !br_taken has no effect on pc or flush.
- Reset mid-operation (any state, counter mid-flush) returns immediately to the reset values above. No request is held across reset.

Decomposition:
- Shared package `core_ctrl_pkg`:
  - typedef enum logic [1:0] { BOOT, RUN, TRAP } pcseq_state_t.
  - localparam alignment-mask helper for InstrBytes.
- One natural sub-module: `flush_timer`, a loadable down-counter with nonzero flag, parameterised by FlushCycles. Reusable by the future exception unit.
- Remainder (FSM, PC register, handshake) lives in pc_sequencer.

Test Plan:
- Reset release, if_ready = 1 steady:
  - if_valid = 0 during BOOT.
  - Then if_addr = 0x0, 0x4, 0x8 on consecutive cycles.
  - flush = 0 and misalign = 0 throughout.
- if_ready = 0 for 3 cycles with pc = 0x10, stall pulsed mid-wait:
  - if_valid stays 1 and if_addr stays 0x10.
  - On accept, pc = 0x14.
- Taken branch, target 0x100, at pc = 0x20, same cycle as accept:
  - flush high for exactly 2 cycles; if_valid = 0 meanwhile.
  - Next accepted fetch is 0x100, then 0x104.
- During the flush window, drive br_valid = 1, br_taken = 1, target 0x200:
  - Ignored; next fetch is still 0x100.
- Taken branch with target 0x102:
  - misalign = 1, flush pulses FlushCycles cycles, if_valid = 0 forever.
  - pc unchanged.
  - Assert rstn = 0 mid-flush: all outputs return to reset values asynchronously.
- pc = 0xFFFFFFFC accepted:
  - pc wraps to 0x0.
  - br_valid with br_taken = 0 at that point: no flush.
